// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: run/pause/step control, load-use stall,
// taken-branch flush and HALT drain for the 5-stage core.
module pipe_seq_ctrl #(
  parameter int NBITS = 32,
  parameter int DRAIN = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_pause,
  input  logic             i_step,
  input  logic             i_id_halt,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_ex_load,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_ma_branch,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_ma_en,
  output logic             o_ma_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_ma_flush,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic [NBITS-1:0] o_cycle_cnt
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    S_PAUSE = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_drain;
  logic [DW-1:0]    w_drain_next;
  logic             r_halted;
  logic [NBITS-1:0] r_cnt;
  logic             w_count;
  logic             w_load_use;

  assign w_load_use = i_ex_load && (i_ex_rt != 5'd0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  always_comb begin
    w_next        = r_state;
    w_drain_next  = r_drain;
    w_count       = 1'b0;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_ma_en    = 1'b0;
    o_ma_wb_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_ex_ma_flush = 1'b0;
    case (r_state)
      S_PAUSE: begin
        if (!i_pause) begin
          if (i_run)       w_next = S_RUN;
          else if (i_step) w_next = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (r_state == S_RUN && i_pause) begin
          w_next = S_PAUSE;
        end else begin
          w_count = 1'b1;
          w_next  = (r_state == S_STEP) ? S_PAUSE : S_RUN;
          if (i_ma_branch) begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_id_ex_en    = 1'b1;
            o_ex_ma_en    = 1'b1;
            o_ma_wb_en    = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            o_ex_ma_flush = 1'b1;
          end else if (i_id_halt || w_load_use) begin
            // Halt and load-use present the same bubble; halt also starts the drain.
            o_id_ex_en    = 1'b1;
            o_id_ex_flush = 1'b1;
            o_ex_ma_en    = 1'b1;
            o_ma_wb_en    = 1'b1;
            if (i_id_halt) begin
              w_next       = S_DRAIN;
              w_drain_next = DW'(DRAIN - 1);
            end
          end else begin
            o_pc_en    = 1'b1;
            o_if_id_en = 1'b1;
            o_id_ex_en = 1'b1;
            o_ex_ma_en = 1'b1;
            o_ma_wb_en = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // A zero counter here is the HALTED condition: nothing moves.
        if (r_drain != '0) begin
          w_count    = 1'b1;
          o_id_ex_en = 1'b1;
          o_ex_ma_en = 1'b1;
          o_ma_wb_en = 1'b1;
          if (i_ma_branch) begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            o_ex_ma_flush = 1'b1;
            w_next        = S_RUN;
            w_drain_next  = '0;
          end else begin
            o_id_ex_flush = 1'b1;
            w_drain_next  = r_drain - DW'(1);
          end
        end
      end
      default: w_next = S_PAUSE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_PAUSE;
      r_drain  <= '0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_drain  <= w_drain_next;
      r_halted <= (w_next == S_DRAIN) && (w_drain_next == '0);
      if (w_count) r_cnt <= r_cnt + NBITS'(1);
    end
  end

  assign o_state     = r_state;
  assign o_halted    = r_halted;
  assign o_cycle_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl with a per-cycle behavioural model and
// literal checkpoints; NBITS=4 so the cycle counter wrap is reachable.
module tb_pipe_seq_ctrl;

  localparam int NB = 4;
  localparam int DR = 3;
  localparam int M_PAUSE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_run = 1'b0, i_pause = 1'b0, i_step = 1'b0;
  logic          i_id_halt = 1'b0;
  logic [4:0]    i_id_rs = '0, i_id_rt = '0, i_ex_rt = '0;
  logic          i_ex_load = 1'b0, i_ma_branch = 1'b0;
  logic          o_pc_en, o_if_id_en, o_id_ex_en, o_ex_ma_en, o_ma_wb_en;
  logic          o_if_id_flush, o_id_ex_flush, o_ex_ma_flush;
  logic [1:0]    o_state;
  logic          o_halted;
  logic [NB-1:0] o_cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_seq_ctrl #(.NBITS(NB), .DRAIN(DR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_pause(i_pause), .i_step(i_step),
    .i_id_halt(i_id_halt), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_load(i_ex_load), .i_ex_rt(i_ex_rt), .i_ma_branch(i_ma_branch),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_id_ex_en(o_id_ex_en),
    .o_ex_ma_en(o_ex_ma_en), .o_ma_wb_en(o_ma_wb_en),
    .o_if_id_flush(o_if_id_flush), .o_id_ex_flush(o_id_ex_flush),
    .o_ex_ma_flush(o_ex_ma_flush), .o_state(o_state), .o_halted(o_halted),
    .o_cycle_cnt(o_cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, remaining drain cycles, advanced-cycle count.
  typedef struct {
    bit pc, e_ifid, e_idex, e_exma, e_mawb, f_ifid, f_idex, f_exma;
    bit adv;
    int nmode;
    int nleft;
  } pred_t;

  int m_mode = M_PAUSE;
  int m_left = 0;
  int m_cnt  = 0;

  function automatic pred_t predict(int mode, int left);
    pred_t p;
    bit lu;
    p = '{default: 0};
    p.nmode = mode;
    p.nleft = left;
    lu = i_ex_load && i_ex_rt != 0 && (i_ex_rt == i_id_rs || i_ex_rt == i_id_rt);
    if (mode == M_PAUSE) begin
      if (!i_pause && i_run) p.nmode = M_RUN;
      else if (!i_pause && i_step) p.nmode = M_STEP;
    end else if (mode == M_RUN && i_pause) begin
      p.nmode = M_PAUSE;
    end else if (mode == M_RUN || mode == M_STEP) begin
      p.adv   = 1;
      p.nmode = (mode == M_STEP) ? M_PAUSE : M_RUN;
      if (i_ma_branch) begin
        {p.pc, p.e_ifid, p.e_idex, p.e_exma, p.e_mawb} = 5'b11111;
        {p.f_ifid, p.f_idex, p.f_exma} = 3'b111;
      end else if (i_id_halt || lu) begin
        {p.e_idex, p.e_exma, p.e_mawb, p.f_idex} = 4'b1111;
        if (i_id_halt) begin
          p.nmode = M_DRAIN;
          p.nleft = DR - 1;
        end
      end else begin
        {p.pc, p.e_ifid, p.e_idex, p.e_exma, p.e_mawb} = 5'b11111;
      end
    end else if (left > 0) begin
      p.adv = 1;
      {p.e_idex, p.e_exma, p.e_mawb, p.f_idex} = 4'b1111;
      if (i_ma_branch) begin
        {p.pc, p.e_ifid, p.f_ifid, p.f_exma} = 4'b1111;
        p.nmode = M_RUN;
        p.nleft = 0;
      end else begin
        p.nleft = left - 1;
      end
    end
    return p;
  endfunction

  always @(posedge clk or posedge i_rst) begin
    pred_t p;
    if (i_rst) begin
      m_mode = M_PAUSE;
      m_left = 0;
      m_cnt  = 0;
    end else begin
      p = predict(m_mode, m_left);
      if (p.adv) m_cnt = (m_cnt + 1) % (1 << NB);
      m_mode = p.nmode;
      m_left = p.nleft;
    end
  end

  always @(negedge clk) begin
    pred_t p;
    p = predict(m_mode, m_left);
    chk("m_pc_en",      32'(o_pc_en),       32'(p.pc));
    chk("m_if_id_en",   32'(o_if_id_en),    32'(p.e_ifid));
    chk("m_id_ex_en",   32'(o_id_ex_en),    32'(p.e_idex));
    chk("m_ex_ma_en",   32'(o_ex_ma_en),    32'(p.e_exma));
    chk("m_ma_wb_en",   32'(o_ma_wb_en),    32'(p.e_mawb));
    chk("m_if_id_fl",   32'(o_if_id_flush), 32'(p.f_ifid));
    chk("m_id_ex_fl",   32'(o_id_ex_flush), 32'(p.f_idex));
    chk("m_ex_ma_fl",   32'(o_ex_ma_flush), 32'(p.f_exma));
    chk("m_state",      32'(o_state),       32'(m_mode));
    chk("m_halted",     32'(o_halted),      32'(m_mode == M_DRAIN && m_left == 0));
    chk("m_cycle_cnt",  32'(o_cycle_cnt),   32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(o_state), 0);
    chk("rst_cnt", 32'(o_cycle_cnt), 0);
    chk("rst_pc_en", 32'(o_pc_en), 0);
    i_rst = 1'b0;

    // Single step twice
    i_step = 1; tick(); i_step = 0; #1;
    chk("step_state", 32'(o_state), 2);
    chk("step_pc_en", 32'(o_pc_en), 1);
    chk("step_mawb", 32'(o_ma_wb_en), 1);
    tick();
    chk("step_back_pause", 32'(o_state), 0);
    chk("step_cnt1", 32'(o_cycle_cnt), 1);
    chk("step_idle_pc", 32'(o_pc_en), 0);
    i_step = 1; tick(); i_step = 0; tick();
    chk("step_cnt2", 32'(o_cycle_cnt), 2);

    // Run, load-use stalls, branch priority
    i_run = 1; tick(); i_run = 0; #1;
    chk("run_state", 32'(o_state), 1);
    i_ex_load = 1; i_ex_rt = 5; i_id_rs = 5; #1;
    chk("lu_pc_en", 32'(o_pc_en), 0);
    chk("lu_ifid_en", 32'(o_if_id_en), 0);
    chk("lu_idex_fl", 32'(o_id_ex_flush), 1);
    chk("lu_exma_en", 32'(o_ex_ma_en), 1);
    tick();
    i_ex_rt = 0; #1;
    chk("lu_r0_pc_en", 32'(o_pc_en), 1);
    chk("lu_r0_idex_fl", 32'(o_id_ex_flush), 0);
    tick();
    i_ex_rt = 5; i_ma_branch = 1; #1;
    chk("br_pc_en", 32'(o_pc_en), 1);
    chk("br_fl_ifid", 32'(o_if_id_flush), 1);
    chk("br_fl_idex", 32'(o_id_ex_flush), 1);
    chk("br_fl_exma", 32'(o_ex_ma_flush), 1);
    tick();
    i_ma_branch = 0; i_id_rs = 0; i_id_rt = 5; #1;
    chk("lu_rt_pc_en", 32'(o_pc_en), 0);
    tick();
    i_ex_load = 0; i_ex_rt = 0; i_id_rt = 0; #1;
    chk("cnt_after_lu", 32'(o_cycle_cnt), 6);

    // Wrong-path halt
    i_id_halt = 1; #1;
    chk("wp_halt_pc", 32'(o_pc_en), 0);
    tick();
    i_id_halt = 0; i_ma_branch = 1; #1;
    chk("wp_drain_state", 32'(o_state), 3);
    chk("wp_br_pc", 32'(o_pc_en), 1);
    chk("wp_br_exma_fl", 32'(o_ex_ma_flush), 1);
    tick();
    i_ma_branch = 0; #1;
    chk("wp_run_state", 32'(o_state), 1);
    chk("wp_not_halted", 32'(o_halted), 0);
    chk("wp_cnt", 32'(o_cycle_cnt), 8);

    // Counter wrap at NBITS=4
    repeat (7) tick();
    chk("wrap_15", 32'(o_cycle_cnt), 15);
    tick();
    chk("wrap_0", 32'(o_cycle_cnt), 0);

    // Pause beats advance; pause beats run in PAUSE
    i_pause = 1; #1;
    chk("pause_pc_en", 32'(o_pc_en), 0);
    tick(); i_pause = 0; #1;
    chk("pause_state", 32'(o_state), 0);
    tick();
    chk("pause_cnt_held", 32'(o_cycle_cnt), 0);
    i_pause = 1; i_run = 1; tick(); i_pause = 0; i_run = 0; #1;
    chk("pause_beats_run", 32'(o_state), 0);
    i_run = 1; tick(); i_run = 0;

    // HALT drain
    i_id_halt = 1; #1;
    chk("h_pc_en", 32'(o_pc_en), 0);
    tick();
    i_id_halt = 0; i_pause = 1; #1;
    chk("h_n1_state", 32'(o_state), 3);
    chk("h_n1_halted", 32'(o_halted), 0);
    chk("h_n1_ifid_en", 32'(o_if_id_en), 0);
    chk("h_n1_idex_fl", 32'(o_id_ex_flush), 1);
    chk("h_n1_mawb", 32'(o_ma_wb_en), 1);
    tick();
    i_pause = 0; #1;
    chk("h_n2_state", 32'(o_state), 3);
    chk("h_n2_halted", 32'(o_halted), 0);
    tick();
    chk("h_n3_halted", 32'(o_halted), 1);
    chk("h_n3_mawb", 32'(o_ma_wb_en), 0);
    chk("h_n3_idex_fl", 32'(o_id_ex_flush), 0);
    chk("h_n3_cnt", 32'(o_cycle_cnt), 3);
    i_run = 1; tick(); i_run = 0; #1;
    chk("h_run_ignored", 32'(o_halted), 1);
    chk("h_run_state", 32'(o_state), 3);
    i_ma_branch = 1; #1;
    chk("h_br_pc", 32'(o_pc_en), 0);
    tick(); i_ma_branch = 0; #1;
    chk("h_br_ignored", 32'(o_halted), 1);
    chk("h_cnt_held", 32'(o_cycle_cnt), 3);

    // Async reset from HALTED, mid-RUN, mid-STEP
    @(posedge clk); #3; i_rst = 1; #1;
    chk("ar_halt_state", 32'(o_state), 0);
    chk("ar_halt_halted", 32'(o_halted), 0);
    tick(); i_rst = 0;
    i_run = 1; tick(); i_run = 0;
    tick(); tick();
    chk("ar_pre_cnt", 32'(o_cycle_cnt), 2);
    #2; i_rst = 1; #1;
    chk("ar_run_state", 32'(o_state), 0);
    chk("ar_run_cnt", 32'(o_cycle_cnt), 0);
    chk("ar_run_pc_en", 32'(o_pc_en), 0);
    chk("ar_run_mawb", 32'(o_ma_wb_en), 0);
    @(negedge clk); #1; i_rst = 0;
    i_step = 1; tick(); i_step = 0; #2;
    i_rst = 1; #1;
    chk("ar_step_state", 32'(o_state), 0);
    chk("ar_step_pc", 32'(o_pc_en), 0);
    @(negedge clk); #1; i_rst = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Drives the PC enable, per-register-stage enables and flushes for IF/ID, ID/EX, EX/MA and MA/WB. Implements run/pause/single-step control from the debug unit, load-use stall insertion, taken-branch flush (branch resolved in MA via the EX/MA `pc_mux_ctrl` output), and HALT drain. Sits beside the pipeline registers in the top level; every pipeline register gains an enable and a synchronous flush driven from here.

## Interface

**Parameters**
- `NBITS`, default 32: width of the cycle counter.
- `DRAIN`, default 3: cycles granted after HALT reaches ID, covering EX, MA and WB.

**Ports** (name, direction, width, meaning)
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_run`, in, 1: debug run request (pulse).
- `i_pause`, in, 1: debug pause request (pulse).
- `i_step`, in, 1: debug single-step request (pulse).
- `i_id_halt`, in, 1: HALT opcode decoded in ID.
- `i_id_rs`, `i_id_rt`, in, 5 each: source registers of the ID instruction.
- `i_ex_load`, in, 1: EX instruction is a load (`flg_mem_op` & load type).
- `i_ex_rt`, in, 5: load destination register in EX.
- `i_ma_branch`, in, 1: EX/MA `o_pc_mux_ctrl`; taken branch or jump in MA.
- `o_pc_en`, out, 1: PC update enable.
- `o_if_id_en`, `o_id_ex_en`, `o_ex_ma_en`, `o_ma_wb_en`, out, 1 each: stage register enables.
- `o_if_id_flush`, `o_id_ex_flush`, `o_ex_ma_flush`, out, 1 each: load bubble (all zeros) on the next edge. Flush overrides enable.
- `o_state`, out, 2: current FSM state.
- `o_halted`, out, 1: high in HALTED.
- `o_cycle_cnt`, out, NBITS: count of advanced cycles.

## Operation

**FSM states (encoding):** PAUSE=2'b00 (reset), RUN=2'b01, STEP=2'b10, DRAIN=2'b11. HALTED is DRAIN with the drain counter at 0, and `o_halted`=1.

**Transitions:**
- PAUSE:
  - `i_pause` → stay. `i_pause` beats `i_run` and `i_step`.
  - else `i_run` → RUN.
  - else `i_step` → STEP.
- RUN:
  - `i_pause` → PAUSE.
  - else advance-cycle rules apply.
  - `i_step` is ignored.
- STEP:
  - Exactly one advance cycle, then → PAUSE.
  - If the halt or branch rules fire in that cycle, they take precedence.
- Advance cycle (RUN/STEP), decision priority:
  1. Branch: `i_ma_branch` → `o_pc_en`=1, flush IF/ID, ID/EX and EX/MA; all enables 1.
  2. Halt: `i_id_halt` → `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1, others enabled. Next state DRAIN; drain counter loads DRAIN−1.
  3. Load-use: `i_ex_load` & `i_ex_rt`≠0 & (`i_ex_rt`==`i_id_rs` | `i_ex_rt`==`i_id_rt`) → `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1, EX/MA and MA/WB enabled.
  4. Otherwise all enables 1, no flush.
- DRAIN (counter>0):
  - PC and IF/ID held; `o_id_ex_flush`=1; EX/MA and MA/WB enabled; counter decrements.
  - `i_ma_branch` in DRAIN: the HALT is on the wrong path. Apply branch flush, clear the counter, go → RUN.
  - `i_pause` is ignored while draining.
- HALTED: all enables 0, no flush. Only `i_rst` exits.
- PAUSE (non-advance): all enables and flushes 0.

**Outputs and counter:**
- Enables and flushes are a combinational decode of the registered state plus current inputs.
- `o_state` and `o_halted` are registered.
- `o_cycle_cnt` increments on each advance cycle and each DRAIN cycle with counter>0. It wraps 2^NBITS−1 → 0 and is held in PAUSE and HALTED.

## Timing

- **Reset (async):** state=PAUSE, drain counter=0, `o_cycle_cnt`=0, `o_halted`=0, `o_state`=0. All enables and flushes read 0.
- **Reset mid-DRAIN or mid-STEP:** immediate return to PAUSE.
- **Step latency:** `i_step` at edge n (in PAUSE) → STEP during cycle n..n+1. Enables are high for that one cycle; PAUSE again after edge n+1.
- **Run/pause latency:** `i_run`/`i_pause` take effect one cycle after sampling. Enables change in the cycle after the request edge.
- **HALT drain:** HALT seen in ID at cycle n. DRAIN occupies cycles n+1 through n+DRAIN−1. `o_halted`=1 from cycle n+DRAIN. The instruction before HALT has completed WB by then.
- **Load-use stall:** lasts exactly one cycle, because the load moves to MA on that edge.
- **Simultaneous events:** branch beats halt, halt beats load-use, and pause beats an advance.

## Test plan

1. **Reset:** assert `i_rst` asynchronously mid-RUN → `o_state`=00, `o_cycle_cnt`=0, all enables 0 before the next clock edge.
2. **Single step:** from PAUSE, pulse `i_step` → exactly one cycle with all enables=1, then PAUSE. `o_cycle_cnt` goes 0→1. A second pulse gives 1→2.
3. **Load-use:** RUN, `i_ex_load`=1, `i_ex_rt`=5, `i_id_rs`=5 → one cycle with `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1.
   - Repeat with `i_ex_rt`=0 → no stall.
4. **Branch priority:** RUN, `i_ma_branch`=1 together with the load-use condition of scenario 3 → `o_pc_en`=1, three flushes=1, no stall.
5. **HALT drain:** RUN, `i_id_halt`=1 at cycle n with DRAIN=3 → `o_state`=11, PC and IF/ID held, `o_halted`=1 at n+3. Pulsing `i_run` then changes nothing; only `i_rst` exits.
6. **Wrong-path halt and wrap:**
   - `i_ma_branch`=1 during the first DRAIN cycle → state returns to RUN, `o_halted` stays 0.
   - With NBITS=4, 16 advance cycles → `o_cycle_cnt` wraps 15→0.
